// File: rtl/input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
//
// Conditions mechanical board inputs (push-button and slide switches) before
// they reach application logic. Each channel is synchronised with a 2-FF chain
// and then qualified by a stability counter. A new value is accepted only
// after it has been seen on the synchroniser output for STABLE_CYCLES
// consecutive cycles. Accepted transitions produce one-cycle rise/fall
// pulses. All outputs are registered.
//
// Parameters
//   N             number of independent channels
//   STABLE_CYCLES consecutive cycles a new value must persist (>= 1)
//   RESET_LEVEL   per-channel value loaded into synchroniser and level_out
//   CNT_W         counter width, derived from STABLE_CYCLES
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   raw_in     in   N  asynchronous raw pin values
//   level_out  out  N  debounced level
//   rise       out  N  one-cycle pulse on an accepted 0->1 transition
//   fall       out  N  one-cycle pulse on an accepted 1->0 transition
//   any_event  out  1  OR of all rise/fall bits, same cycle as the pulses
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module input_debouncer #(
    parameter int           N             = 5,
    parameter int           STABLE_CYCLES = 500000,
    parameter logic [N-1:0] RESET_LEVEL   = {N{1'b1}},
    parameter int           CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] level_out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         any_event
);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Counter value reached on the cycle before acceptance. With
    // STABLE_CYCLES = 1 this is 0, so a mismatch is accepted straight from
    // STABLE and level_out simply tracks sync2 one cycle later.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N-1:0]     sync1;
    logic [N-1:0]     sync2;
    state_t           state_q [N];
    state_t           state_d [N];
    logic [CNT_W-1:0] cnt_q   [N];
    logic [CNT_W-1:0] cnt_d   [N];
    logic [N-1:0]     level_d;
    logic [N-1:0]     rise_d;
    logic [N-1:0]     fall_d;
    logic [N-1:0]     diff;

    assign diff = sync2 ^ level_out;

    // Next-state / output decode, one independent FSM per channel.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_out;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N; i++) begin
            if (!diff[i]) begin
                // Glitch ended (or nothing happening): drop any partial count
                // so the next deviation starts qualification from scratch.
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = sync2[i];
                rise_d[i]  = sync2[i];
                fall_d[i]  = ~sync2[i];
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    STABLE: begin
                        state_d[i] = PENDING;
                        cnt_d[i]   = CNT_W'(1);
                    end
                    default: begin
                        state_d[i] = PENDING;
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                    end
                endcase
            end
        end
    end

    // Synchroniser, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= RESET_LEVEL;
            sync2     <= RESET_LEVEL;
            level_out <= RESET_LEVEL;
            rise      <= '0;
            fall      <= '0;
            any_event <= 1'b0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1     <= raw_in;
            sync2     <= sync1;
            level_out <= level_d;
            rise      <= rise_d;
            fall      <= fall_d;
            any_event <= |(rise_d | fall_d);
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// ----------------------------------------------------------------------------
// tb_input_debouncer
//
// Self-checking bench for input_debouncer with N=2, STABLE_CYCLES=4,
// RESET_LEVEL=2'b11 and a 20 ns clock. Directed vectors come from a table and
// from short hand-written sequences; a randomized phase is compared against a
// sliding-window reference model: a channel's level flips when the last
// STABLE_CYCLES synchronised samples since reset all differ from it.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_input_debouncer;

    localparam int         N   = 2;
    localparam int         S   = 4;
    localparam logic [1:0] RL  = 2'b11;
    localparam int         NONE = -1;

    logic       clk;
    logic       reset;
    logic [1:0] raw_in;
    logic [1:0] level_out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       any_event;

    int vectors;
    int miscompares;

    input_debouncer #(
        .N             (N),
        .STABLE_CYCLES (S),
        .RESET_LEVEL   (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .level_out (level_out),
        .rise      (rise),
        .fall      (fall),
        .any_event (any_event)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    logic [1:0] m_s1, m_s2, m_level, m_rise, m_fall;
    logic       m_any;
    logic [1:0] m_win [S];
    int         m_n;

    always @(posedge clk) begin : model
        logic [1:0] win [S];
        int         n;
        logic [1:0] lvl, r, f;
        logic       all_diff;
        if (reset) begin
            m_s1    <= RL;
            m_s2    <= RL;
            m_level <= RL;
            m_rise  <= '0;
            m_fall  <= '0;
            m_any   <= 1'b0;
            m_n     <= 0;
        end else begin
            for (int k = 0; k < S - 1; k++) win[k] = m_win[k + 1];
            win[S - 1] = m_s2;
            n   = (m_n < S) ? m_n + 1 : S;
            lvl = m_level;
            r   = '0;
            f   = '0;
            if (n == S) begin
                for (int ch = 0; ch < N; ch++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < S; k++)
                        if (win[k][ch] == m_level[ch]) all_diff = 1'b0;
                    if (all_diff) begin
                        lvl[ch] = ~m_level[ch];
                        if (lvl[ch]) r[ch] = 1'b1;
                        else         f[ch] = 1'b1;
                    end
                end
            end
            m_win   <= win;
            m_n     <= n;
            m_level <= lvl;
            m_rise  <= r;
            m_fall  <= f;
            m_any   <= |(r | f);
            m_s2    <= m_s1;
            m_s1    <= raw_in;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [1:0] lv, input logic [1:0] rs,
                         input logic [1:0] fl, input logic an);
        vectors++;
        if (level_out !== lv || rise !== rs || fall !== fl || any_event !== an) begin
            miscompares++;
            $display("FAIL %s @%0t: got level=%b rise=%b fall=%b any=%b, want level=%b rise=%b fall=%b any=%b",
                     nm, $time, level_out, rise, fall, any_event, lv, rs, fl, an);
        end
    endtask

    // Hold inputs for n edges. Before edge index 'at' the level is lv0 with no
    // pulses; at 'at' the level becomes lv1 with the given pulses; afterwards
    // lv1 and quiet. at = NONE means nothing is expected to happen.
    task automatic run_expect(input string nm, input logic r, input logic [1:0] raw,
                              input int n, input int at, input logic [1:0] lv0,
                              input logic [1:0] lv1, input logic [1:0] rs,
                              input logic [1:0] fl);
        for (int k = 0; k < n; k++) begin
            reset  = r;
            raw_in = raw;
            @(posedge clk);
            #1;
            if (at >= 0 && k == at)     check(nm, lv1, rs, fl, |(rs | fl));
            else if (at >= 0 && k > at) check(nm, lv1, 2'b00, 2'b00, 1'b0);
            else                        check(nm, lv0, 2'b00, 2'b00, 1'b0);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] raw;
        logic [1:0] level;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       any;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic [1:0] raw,
                       input logic [1:0] lv, input logic [1:0] rs,
                       input logic [1:0] fl, input logic an);
        vec_t v;
        v = '{rst: r, raw: raw, level: lv, rise: rs, fall: fl, any: an};
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        raw_in      = 2'b00;

        // Reset with pins low, release -> fall on both 5 edges later,
        // then rise on both, then a clean press on channel 0.
        add(3, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        add(5, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        add(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);
        add(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add(5, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        add(1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1);
        add(1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        add(5, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00, 1'b0);
        add(1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b01, 1'b1);
        add(2, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0);

        foreach (tbl[i]) begin
            reset  = tbl[i].rst;
            raw_in = tbl[i].raw;
            @(posedge clk);
            #1;
            check($sformatf("table[%0d]", i), tbl[i].level, tbl[i].rise,
                  tbl[i].fall, tbl[i].any);
            @(negedge clk);
        end

        // Glitch on channel 1: 3 cycles low is too short to qualify.
        run_expect("glitch_lo", 1'b0, 2'b00, 3,  NONE, 2'b10, 2'b10, 2'b00, 2'b00);
        run_expect("glitch_hi", 1'b0, 2'b10, 20, NONE, 2'b10, 2'b10, 2'b00, 2'b00);

        // Bounce on channel 0, then settle low.
        run_expect("bounce_prep", 1'b0, 2'b11, 6, 5, 2'b10, 2'b11, 2'b01, 2'b00);
        for (int b = 0; b < 2; b++) begin
            run_expect("bounce_lo", 1'b0, 2'b10, 2, NONE, 2'b11, 2'b11, 2'b00, 2'b00);
            run_expect("bounce_hi", 1'b0, 2'b11, 2, NONE, 2'b11, 2'b11, 2'b00, 2'b00);
        end
        run_expect("bounce_settle", 1'b0, 2'b10, 8, 5, 2'b11, 2'b10, 2'b00, 2'b01);

        // Simultaneous fall on both channels.
        run_expect("simul_prep", 1'b0, 2'b11, 6, 5, 2'b10, 2'b11, 2'b01, 2'b00);
        run_expect("simul_fall", 1'b0, 2'b00, 8, 5, 2'b11, 2'b00, 2'b00, 2'b11);

        // Reset while channel 0 is pending: change discarded, requalified.
        run_expect("rstpend_prep", 1'b0, 2'b11, 6, 5, 2'b00, 2'b11, 2'b11, 2'b00);
        run_expect("rstpend_lo",   1'b0, 2'b10, 3, NONE, 2'b11, 2'b11, 2'b00, 2'b00);
        run_expect("rstpend_rst",  1'b1, 2'b10, 1, NONE, 2'b11, 2'b11, 2'b00, 2'b00);
        run_expect("rstpend_rel",  1'b0, 2'b10, 8, 5, 2'b11, 2'b10, 2'b00, 2'b01);

        // Randomized phase against the reference model.
        begin
            int hold;
            hold = 0;
            for (int c = 0; c < 800; c++) begin
                if (hold == 0) begin
                    raw_in = 2'($urandom_range(0, 3));
                    hold   = $urandom_range(1, 8);
                end
                hold--;
                reset = ($urandom_range(0, 99) == 0);
                @(posedge clk);
                #1;
                check("random", m_level, m_rise, m_fall, m_any);
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions the board's mechanical inputs (push-button KEY[1], slide switches SW[3:0]) before they reach the application logic inside `Top`. Each channel is synchronised to the system clock and qualified by a stability counter. The block outputs a clean level plus single-cycle rise and fall pulses per channel. It sits between the FPGA pins and every consumer of KEY/SW, clocked from `FPGA_CLK1_50` and reset by the system reset derived from KEY[0].

## Interface
Parameters:
- `N`, 5, number of independent channels (KEY[1] + SW[3:0]).
- `STABLE_CYCLES`, 500000, consecutive cycles a new input value must persist before it is accepted; 10 ms at 50 MHz; minimum 1; benches override with a small value.
- `RESET_LEVEL`, {N{1'b1}}, per-channel value loaded into synchroniser and `level_out` on reset (KEY idles high).
- `CNT_W`, $clog2(STABLE_CYCLES+1), counter width; derived, never overridden.

Ports:
- `clk`  in  1  system clock, 50 MHz (`FPGA_CLK1_50`).
- `reset`  in  1  synchronous, active-high reset.
- `raw_in`  in  N  asynchronous raw pin values.
- `level_out`  out  N  debounced level.
- `rise`  out  N  one-cycle pulse when `level_out[i]` goes 0->1.
- `fall`  out  N  one-cycle pulse when `level_out[i]` goes 1->0.
- `any_event`  out  1  OR-reduction of `rise | fall`, registered with them (same cycle).

## Operation
- Per channel: 2-FF synchroniser `sync1 -> sync2`; only `sync2` is used downstream.
- Per-channel FSM, 2 states:
  - STABLE: `sync2 == level_out`, counter held at 0.
  - PENDING: `sync2 != level_out`, counter increments by 1 each cycle.
- STABLE -> PENDING on the first cycle `sync2 != level_out`; counter becomes 1.
- In PENDING with `sync2 == level_out` (glitch ended): -> STABLE, counter cleared, no output change.
- In PENDING with `sync2 != level_out` and counter == STABLE_CYCLES-1: `level_out <= sync2`, pulse `rise` or `fall` matching the direction, counter cleared, -> STABLE.
- Counter never exceeds STABLE_CYCLES-1; no wrap is possible.
- Channels are fully independent; simultaneous events on several channels each produce their own pulse in the same cycle.
- STABLE_CYCLES = 1: `level_out` follows `sync2` with one cycle of delay; every `sync2` change produces a pulse.

## Timing
- Reset (synchronous, sampled on `clk` rising edge): `sync1 = sync2 = level_out = RESET_LEVEL`, counters 0, all FSMs STABLE, `rise = fall = 0`, `any_event = 0`.
- `reset` asserted mid-PENDING: the pending change is discarded. After release, if the pin differs from RESET_LEVEL, a full qualification restarts from counter 0.
- Latency: raw value first sampled by `sync1` at edge E0 and held steady -> `level_out`, `rise`/`fall` and `any_event` update at edge E0+STABLE_CYCLES+1.
- `rise`/`fall` are high for exactly one cycle per accepted transition; never both on the same channel.
- Glitch: any deviation seen on `sync2` for fewer than STABLE_CYCLES consecutive cycles produces no output activity.
- Input toggling back during PENDING restarts qualification from 0 on the next deviation; there is no accumulation across glitches.
- All outputs are registered; no combinational path from `raw_in`.

## Test plan
Benches use N=2, STABLE_CYCLES=4, RESET_LEVEL=2'b11, 20 ns clock.
- Reset: hold `reset`=1 for 3 cycles with `raw_in`=2'b00 -> `level_out`=2'b11, `rise`=`fall`=0 during reset. After release, `fall`=2'b11 pulses once, exactly 5 edges after first sampling.
- Clean press: `raw_in[0]` 1->0 held -> `level_out[0]`=0 at edge E0+5, `fall[0]` high for one cycle, `any_event`=1 in that cycle, channel 1 untouched.
- Glitch: `raw_in[1]` low for 3 cycles, then high -> no change on `level_out`, `rise`, `fall` or `any_event` for 20 cycles.
- Bounce: `raw_in[0]` toggles 0,1,0,1 every 2 cycles, then settles at 0 -> exactly one `fall[0]` pulse, 5 edges after the final settle is sampled.
- Simultaneous: both channels 1->0 in the same cycle -> `fall`=2'b11 in one cycle, `any_event` high for exactly 1 cycle.
- Reset mid-PENDING: `raw_in[0]`=0 for 3 cycles, then `reset` for 1 cycle -> no pulse. `level_out[0]`=1 after reset; with the input held at 0, `fall[0]` appears 5 edges after reset release.
